// File: rtl/irda_ctrl_regbank.sv
// Wishbone control-register bank for the IrDA core; master writes are staged and applied while the link is idle.
// Latency: ack and read data one cycle after the request; Wishbone slave never stalls beyond the one-cycle ack.
// Build option: define IRDA_REGBANK_LOCK_EN to add the write-lock and sticky write-error status bits.
module irda_ctrl_regbank #(
    parameter int              DW      = 8,
    parameter int              NREG    = 4,
    parameter int              AW      = 4,
    parameter logic [DW-1:0]   MST_RST = '0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AW-1:0]      wb_adr_i,
    input  logic [DW-1:0]      wb_dat_i,
    output logic [DW-1:0]      wb_dat_o,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    input  logic               link_idle_i,
    output logic [NREG*DW-1:0] ctrl_o,
    output logic               fast_mode,
    output logic               mir_mode,
    output logic               mir_half,
    output logic               fir_mode,
    output logic               tx_select,
    output logic               loopback_enable,
    output logic               use_dma,
    output logic               upd_pending_o,
    output logic               upd_done_o
);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic [DW-1:0]           active_q, active_d;
    logic [NREG-1:1][DW-1:0] creg_q, creg_d;
    logic                    ack_q, ack_d;
    logic [DW-1:0]           dat_q, dat_d;
    logic                    done_q, done_d;

    logic          req, wr, mst_wr;
    logic          adr_mst, adr_sts, adr_ctl;
    logic          lock_st, wr_err_st;
    logic [DW-1:0] status, rd_val;

    always_comb begin
        req     = wb_cyc_i & wb_stb_i & ~ack_q;
        wr      = req & wb_we_i;
        adr_mst = (wb_adr_i == '0);
        adr_sts = (wb_adr_i == AW'(NREG));
        adr_ctl = !adr_mst && (wb_adr_i < AW'(NREG));
        mst_wr  = wr & adr_mst & ~lock_st;
        status  = {{(DW-3){1'b0}}, wr_err_st, lock_st, (state_q == ST_PEND)};
    end

    // Read mux samples pre-edge state, so a master read returns the value currently driving the PHY.
    always_comb begin
        rd_val = '0;
        if (adr_mst) begin
            rd_val = active_q;
        end else if (adr_sts) begin
            rd_val = status;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_adr_i == AW'(i)) rd_val = creg_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        creg_d   = creg_q;
        done_d   = 1'b0;
        ack_d    = req;
        dat_d    = req ? rd_val : dat_q;
        case (state_q)
            ST_IDLE: if (mst_wr) state_d = ST_PEND;
            ST_PEND: begin
                // A fresh master write holds off the apply so the newest value is what lands.
                if (!mst_wr && link_idle_i) begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (mst_wr) shadow_d = wb_dat_i;
        for (int i = 1; i < NREG; i++) begin
            if (wr && !lock_st && wb_adr_i == AW'(i)) creg_d[i] = wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= MST_RST;
            active_q <= MST_RST;
            creg_q   <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            creg_q   <= creg_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
        end
    end

`ifdef IRDA_REGBANK_LOCK_EN
    logic lock_q, lock_d, wr_err_q, wr_err_d;

    always_comb begin
        lock_d   = lock_q;
        wr_err_d = wr_err_q;
        if (wr && adr_sts) begin
            lock_d = wb_dat_i[1];
            if (!wb_dat_i[1]) wr_err_d = 1'b0;
        end else if (wr && lock_q && (adr_mst || adr_ctl)) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lock_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign lock_st   = lock_q;
    assign wr_err_st = wr_err_q;
`else
    assign lock_st   = 1'b0;
    assign wr_err_st = 1'b0;
`endif

    assign wb_ack_o        = ack_q;
    assign wb_dat_o        = dat_q;
    assign ctrl_o          = {creg_q, active_q};
    assign fast_mode       = (active_q[6:5] != 2'b00);
    assign mir_mode        = active_q[4];
    assign mir_half        = (active_q[6:5] == 2'b10);
    assign fir_mode        = (active_q[6:5] == 2'b01);
    assign tx_select       = active_q[1];
    assign loopback_enable = active_q[2];
    assign use_dma         = active_q[7];
    assign upd_pending_o   = (state_q == ST_PEND);
    assign upd_done_o      = done_q;

endmodule

// File: tb/tb_irda_ctrl_regbank.sv
// Bench for irda_ctrl_regbank: directed scenarios then random Wishbone/link traffic against a transaction-level model.
module tb_irda_ctrl_regbank;
    localparam int            DW      = 8;
    localparam int            NREG    = 4;
    localparam int            AW      = 4;
    localparam logic [DW-1:0] MST_RST = 8'h00;

    logic               clk = 1'b0;
    logic               rst, cyc, stb, we, idle;
    logic [AW-1:0]      adr;
    logic [DW-1:0]      dat_i, dat_o;
    logic               ack;
    logic [NREG*DW-1:0] ctrl_o;
    logic fast_mode, mir_mode, mir_half, fir_mode, tx_select, loopback_enable, use_dma;
    logic upd_pending_o, upd_done_o;

    irda_ctrl_regbank #(.DW(DW), .NREG(NREG), .AW(AW), .MST_RST(MST_RST)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack), .link_idle_i(idle),
        .ctrl_o(ctrl_o), .fast_mode(fast_mode), .mir_mode(mir_mode), .mir_half(mir_half),
        .fir_mode(fir_mode), .tx_select(tx_select), .loopback_enable(loopback_enable),
        .use_dma(use_dma), .upd_pending_o(upd_pending_o), .upd_done_o(upd_done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register contents, one staged master value, and flags.
    logic [DW-1:0] m_active, m_shadow, m_dat;
    logic [DW-1:0] m_regs [NREG];
    logic          m_pend, m_done, m_ack, m_lock, m_err;

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == 0)    return m_active;
        if (a < NREG)  return m_regs[a];
        if (a == NREG) return DW'({m_err, m_lock, m_pend});
        return '0;
    endfunction

    task automatic model_edge();
        bit req, wr, mwr, apply;
        int a;
        logic [DW-1:0] rdv;
        if (rst) begin
            m_active = MST_RST; m_shadow = MST_RST; m_dat = '0;
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_pend = 0; m_done = 0; m_ack = 0; m_lock = 0; m_err = 0;
        end else begin
            a     = int'(adr);
            req   = cyc && stb && !m_ack;
            wr    = req && we;
            mwr   = wr && a == 0 && !m_lock;
            rdv   = m_read(a);
            apply = m_pend && !mwr && idle;
            m_done = apply;
            if (apply) begin m_active = m_shadow; m_pend = 0; end
            if (mwr) begin m_shadow = dat_i; m_pend = 1; end
            if (wr && a > 0 && a < NREG && !m_lock) m_regs[a] = dat_i;
`ifdef IRDA_REGBANK_LOCK_EN
            if (wr && a == NREG) begin
                m_lock = dat_i[1];
                if (!dat_i[1]) m_err = 0;
            end else if (wr && a < NREG && m_lock) begin
                m_err = 1;
            end
`endif
            m_ack = req;
            if (req) m_dat = rdv;
        end
    endtask

    task automatic compare();
        int spd;
        spd = int'(m_active[6:5]);
        chk("ack", ack, m_ack);
        if (m_ack) chk("rdata", dat_o, m_dat);
        chk("master", ctrl_o[DW-1:0], m_active);
        for (int i = 1; i < NREG; i++) chk("ctrl_reg", ctrl_o[i*DW +: DW], m_regs[i]);
        chk("pending", upd_pending_o, m_pend);
        chk("done", upd_done_o, m_done);
        chk("fast_mode", fast_mode, spd > 0);
        chk("fir_mode", fir_mode, spd == 1);
        chk("mir_half", mir_half, spd == 2);
        chk("mir_mode", mir_mode, m_active[4]);
        chk("tx_select", tx_select, m_active[1]);
        chk("loopback", loopback_enable, m_active[2]);
        chk("use_dma", use_dma, m_active[7]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // One complete transfer: request cycle (ack rises), then an idle bus cycle.
    task automatic bus(input logic w, input int a, input logic [DW-1:0] d, output logic [DW-1:0] rd);
        cyc = 1; stb = 1; we = w; adr = AW'(a); dat_i = d;
        step();
        chk("bus_ack", ack, 1'b1);
        rd = dat_o;
        cyc = 0; stb = 0; we = 0;
        step();
    endtask

    logic [DW-1:0] rd;
    bit ack_pat [6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat_i = '0; idle = 0;
        step(); step();
        rst = 0;
        step();
        chk("rst_master", ctrl_o[DW-1:0], MST_RST);
        chk("rst_ack", ack, 1'b0);
        chk("rst_pend", upd_pending_o, 1'b0);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_decode", {fast_mode, mir_mode, mir_half, fir_mode, tx_select, loopback_enable, use_dma}, 7'd0);

        // Master write with idle link: one pending cycle, then apply.
        idle = 1;
        cyc = 1; stb = 1; we = 1; adr = '0; dat_i = 8'h22;
        step();
        chk("t2_ack", ack, 1'b1);
        chk("t2_pend", upd_pending_o, 1'b1);
        chk("t2_not_applied", ctrl_o[DW-1:0], 8'h00);
        cyc = 0; stb = 0; we = 0;
        step();
        chk("t2_done", upd_done_o, 1'b1);
        chk("t2_fast", fast_mode, 1'b1);
        chk("t2_fir", fir_mode, 1'b1);
        chk("t2_tx", tx_select, 1'b1);
        step();
        chk("t2_done_pulse", upd_done_o, 1'b0);

        // Busy link: newest staged value wins once idle returns.
        idle = 0;
        bus(1, 0, 8'h40, rd);
        bus(1, 0, 8'h84, rd);
        chk("t3_held", ctrl_o[DW-1:0], 8'h22);
        bus(0, NREG, 8'h00, rd);
        chk("t3_status", rd, 8'h01);
        idle = 1;
        step();
        chk("t3_active", ctrl_o[DW-1:0], 8'h84);
        chk("t3_dma", use_dma, 1'b1);

        bus(1, 1, 8'hA5, rd);
        bus(0, 1, 8'h00, rd);
        chk("t4_rd1", rd, 8'hA5);
        bus(0, NREG + 1, 8'h00, rd);
        chk("t4_rd_oor", rd, 8'h00);
        bus(0, 0, 8'h00, rd);
        chk("t4_rd_master", rd, 8'h84);

`ifdef IRDA_REGBANK_LOCK_EN
        bus(1, NREG, 8'h02, rd);
        bus(1, 1, 8'h11, rd);
        chk("t6_locked", ctrl_o[DW +: DW], 8'hA5);
        bus(0, NREG, 8'h00, rd);
        chk("t6_status", rd, 8'h06);
        bus(1, NREG, 8'h00, rd);
        bus(0, NREG, 8'h00, rd);
        chk("t6_cleared", rd, 8'h00);
`endif

        // Strobe held: one transfer every other cycle.
        cyc = 1; stb = 1; we = 0; adr = AW'(1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_ack_pat", ack, ack_pat[i]);
        end
        cyc = 0; stb = 0;
        step();
        idle = 0;
        bus(1, 0, 8'h5A, rd);
        chk("t5_pend", upd_pending_o, 1'b1);
        rst = 1;
        step();
        rst = 0;
        step();
        chk("t5_rst_pend", upd_pending_o, 1'b0);
        chk("t5_rst_master", ctrl_o[DW-1:0], MST_RST);
        idle = 1;
        step();
        chk("t5_discarded", ctrl_o[DW-1:0], MST_RST);

        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            adr   = AW'($urandom_range(0, NREG + 2));
            dat_i = DW'($urandom);
            idle  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
